// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, condition and state encodings plus flag bit positions
package alu_pkg;
   typedef enum logic [2:0] {OP_ADD = 3'b000, OP_SUB, OP_AND, OP_SLL, OP_SRL, OP_ILL = 3'b111} op_e;
   typedef enum logic [2:0] {CC_EQ, CC_NE, CC_LTU, CC_GEU, CC_LT, CC_GE, CC_MI, CC_AL} cond_e;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   function automatic logic op_legal(input logic [2:0] op);
      return op <= 3'(OP_SRL);
   endfunction
endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates a branch-style condition code against an {N,Z,C,V} flag vector
module cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] flags_i,
   input  logic [2:0] cond_sel_i,
   output logic       cond_true_o
);
   logic n, z, c, v;
   assign n = flags_i[FLAG_N];
   assign z = flags_i[FLAG_Z];
   assign c = flags_i[FLAG_C];
   assign v = flags_i[FLAG_V];
   always_comb begin
      cond_true_o = 1'b1;
      case (cond_e'(cond_sel_i))
         CC_EQ:   cond_true_o = z;
         CC_NE:   cond_true_o = ~z;
         CC_LTU:  cond_true_o = c;
         CC_GEU:  cond_true_o = ~c;
         CC_LT:   cond_true_o = n ^ v;
         CC_GE:   cond_true_o = ~(n ^ v);
         CC_MI:   cond_true_o = n;
         default: cond_true_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one request at a time through an external ALU and
// returns the registered result, with an architectural flag register.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic              req_setflags,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   input  logic              alu_zero,
   input  logic              alu_negative,
   input  logic              alu_overflow,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [3:0]        rsp_flags,
   output logic              rsp_err,
   output logic [3:0]        flags_q,
   input  logic [2:0]        cond_sel,
   output logic              cond_true
);
   state_e            state_q;
   op_e               op_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic              setflags_q;
   logic [3:0]        alu_f;
   logic              err;
   always_comb begin
      alu_f         = '0;
      alu_f[FLAG_N] = alu_negative;
      alu_f[FLAG_Z] = alu_zero;
      alu_f[FLAG_C] = alu_carry;
      alu_f[FLAG_V] = alu_overflow;
   end
   // illegal opcodes are folded to OP_ILL at accept time, so the ALU sees 3'b111
   assign err        = op_q == OP_ILL;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_opcode = op_q;
   assign req_ready  = state_q == S_IDLE;
   assign rsp_valid  = state_q == S_RESP;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= OP_ADD;
         a_q        <= '0;
         b_q        <= '0;
         setflags_q <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_err    <= 1'b0;
         flags_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid) begin
               op_q       <= op_legal(req_op) ? op_e'(req_op) : OP_ILL;
               a_q        <= req_a;
               b_q        <= req_b;
               setflags_q <= req_setflags;
               state_q    <= S_EXEC;
            end
            S_EXEC: begin
               rsp_result <= err ? '0 : alu_result;
               rsp_flags  <= err ? '0 : alu_f;
               rsp_err    <= err;
               if (setflags_q && !err) flags_q <= alu_f;
               state_q    <= S_RESP;
            end
            S_RESP: if (rsp_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
   cond_eval u_cond (
      .flags_i     (flags_q),
      .cond_sel_i  (cond_sel),
      .cond_true_o (cond_true)
   );
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench driving alu_sequencer with a behavioural external ALU
module tb_alu_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_setflags = 1'b0;
   logic [2:0]  req_op = '0;
   logic [31:0] req_a = '0, req_b = '0;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_opcode;
   logic        alu_carry, alu_zero, alu_negative, alu_overflow;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags, flags_q;
   logic [2:0]  cond_sel = '0;
   logic        cond_true;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flags;
      logic        err;
      logic [31:0] a;
      logic [3:0]  fq;
   } exp_t;
   exp_t        sb[$];
   int          n_cmp = 0, n_bad = 0;
   logic [3:0]  exp_fq = '0;

   always #5 clk = ~clk;

   alu_sequencer #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_setflags(req_setflags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .alu_negative(alu_negative), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err), .flags_q(flags_q),
      .cond_sel(cond_sel), .cond_true(cond_true)
   );

   // external ALU: returns {N,Z,C,V,result}; SUB carry is the borrow
   function automatic logic [35:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] r;
      logic        c, v;
      w = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
         3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
         3'd2: r = a & b;
         3'd3: r = a << b[4:0];
         3'd4: r = a >> b[4:0];
         default: r = 32'hDEAD_BEEF;
      endcase
      return {r[31], r == 32'd0, c, v, r};
   endfunction

   function automatic logic exp_cond(input logic [3:0] f, input int sel);
      case (sel)
         0: return f[2];
         1: return ~f[2];
         2: return f[1];
         3: return ~f[1];
         4: return f[3] ^ f[0];
         5: return ~(f[3] ^ f[0]);
         6: return f[3];
         default: return 1'b1;
      endcase
   endfunction

   always_comb {alu_negative, alu_zero, alu_carry, alu_overflow, alu_result} = alu_model(alu_opcode, alu_a, alu_b);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic sf,
                       input logic [31:0] eres, input logic [3:0] eflags, input logic eerr);
      int t = 0;
      while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
      check("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_setflags = sf;
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom; req_setflags = 1'b1;
      check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      check("exec_req_ready", 32'(req_ready), 32'd0);
      check("alu_opcode", 32'(alu_opcode), eerr ? 32'd7 : 32'(op));
      check("alu_a", alu_a, a);
      check("alu_b", alu_b, b);
      if (sf && !eerr) exp_fq = eflags;
      sb.push_back('{eres, eflags, eerr, a, exp_fq});
   endtask

   task automatic recv(input int hold);
      exp_t e;
      int   t = 0;
      while (!rsp_valid && t < 10) begin @(posedge clk); #1; t++; end
      check("latency", 32'(t), 32'd1);
      if (sb.size() == 0) begin check("sb_empty", 32'd1, 32'd0); return; end
      e = sb.pop_front();
      check("rsp_result", rsp_result, e.res);
      check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
      check("rsp_err", 32'(rsp_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_a = ~e.a;
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_result", rsp_result, e.res);
         check("hold_flags", 32'(rsp_flags), 32'(e.flags));
         check("hold_req_ready", 32'(req_ready), 32'd0);
         check("hold_alu_a", alu_a, e.a);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_taken", 32'(rsp_valid), 32'd0);
      check("flags_q", 32'(flags_q), 32'(e.fq));
      check("idle_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic cond_at(input int sel, input logic exp);
      cond_sel = 3'(sel);
      @(negedge clk);
      check($sformatf("cond%0d", sel), 32'(cond_true), 32'(exp));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [35:0] m;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        sf, er;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_flags_q", 32'(flags_q), 32'd0);
      check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("idle_rsp_ready_valid", 32'(rsp_valid), 32'd0);
      check("idle_rsp_ready_ready", 32'(req_ready), 32'd1);

      send(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1001, 1'b0);
      recv(0);
      cond_at(4, 1'b0);
      send(3'b001, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 4'b1010, 1'b0);
      recv(3);
      cond_at(2, 1'b1);
      cond_at(4, 1'b1);
      cond_at(5, 1'b0);
      send(3'b110, 32'h12, 32'h34, 1'b1, 32'd0, 4'b0000, 1'b1);
      recv(0);
      send(3'b001, 32'd9, 32'd9, 1'b0, 32'd0, 4'b0100, 1'b0);
      recv(0);
      check("flags_kept", 32'(flags_q), 32'hA);

      for (int i = 0; i < 12; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 3 == 0) ? a : $urandom;
         sf = 1'($urandom);
         er = op > 3'd4;
         m  = alu_model(op, a, b);
         send(op, a, b, sf, er ? 32'd0 : m[31:0], er ? 4'd0 : m[35:32], er);
         recv($urandom_range(0, 2));
      end
      for (int i = 0; i < 8; i++) cond_at(i, exp_cond(exp_fq, i));

      send(3'b000, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 4'b0110, 1'b0);
      recv(0);
      req_valid = 1'b1; req_op = 3'b001; req_a = 32'd1; req_b = 32'd2; req_setflags = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_flags_q", 32'(flags_q), 32'd0);
      check("mid_rst_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_fq = '0;
      @(posedge clk); #1;
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_flags_q", 32'(flags_q), 32'd0);
      send(3'b000, 32'd2, 32'd3, 1'b1, 32'd5, 4'b0000, 1'b0);
      recv(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
